volcado_memoria_datos: RTL and testbench
========================================

// Module: volcado_memoria_datos
// PURPOSE
//  Dump engine downstream of the BIP I data memory (16-bit, 1-cycle negedge read).
//  After the processor halts, it reads N_WORDS words from address 0 upward.
//  It sends each word to the UART TX as two bytes, high byte first.
//  It owns the memory address bus only while dumping (o_mem_owner), so the top level can mux it.
// PARAMETERS
//  RAM_WIDTH   16    data memory word width (fixed at 2*NB_UART)
//  RAM_DEPTH   1024  data memory depth
//  ADDR_WIDTH  10    address width, clog2(RAM_DEPTH)
//  NB_UART     8     UART byte width
//  N_WORDS     1024  words dumped per run, legal range 1..RAM_DEPTH
// PORTS
//  i_clk        in   1           system clock; all state on posedge
//  i_reset      in   1           synchronous, active-low reset
//  i_start      in   1           start pulse (processor halt); sampled only in IDLE
//  i_mem_data   in   RAM_WIDTH   data memory read port output
//  o_mem_addr   out  ADDR_WIDTH  data memory address
//  o_mem_wea    out  1           data memory write enable; constant 0
//  o_mem_owner  out  1           1 = this block drives the memory address
//  i_tx_done    in   1           UART TX byte-finished tick (1 cycle)
//  o_tx_start   out  1           UART TX start pulse (1 cycle)
//  o_tx_data    out  NB_UART     byte to transmit; held stable until i_tx_done
//  o_busy       out  1           1 in every state except IDLE
//  o_done       out  1           1-cycle pulse when the last byte has finished
// BEHAVIOUR
//  Reset (i_reset==0 at posedge): state=IDLE, o_mem_addr=0, word register=0, o_tx_data=0.
//   o_tx_start, o_busy, o_done and o_mem_owner are 0. Reset mid-dump aborts immediately.
//   No pending byte is resent after an abort.
//  FSM states: IDLE, READ, LATCH, TX_HI, WAIT_HI, TX_LO, WAIT_LO, FIN.
//  IDLE:    i_start=1 -> READ with o_mem_addr=0. Otherwise stay.
//  READ:    o_mem_addr is stable. The memory samples it on the following negedge.
//           Next state is LATCH.
//  LATCH:   capture i_mem_data into the word register -> TX_HI.
//           This gives 1 cycle of read latency after READ.
//  TX_HI:   o_tx_start=1 for exactly this cycle, o_tx_data=word[15:8] -> WAIT_HI.
//  WAIT_HI: hold o_tx_data. i_tx_done=1 -> TX_LO.
//  TX_LO:   o_tx_start=1, o_tx_data=word[7:0] -> WAIT_LO.
//  WAIT_LO: on i_tx_done=1:
//           if o_mem_addr==N_WORDS-1 -> FIN
//           else o_mem_addr+1 and -> READ
//  FIN:     o_done=1 for this single cycle -> IDLE. o_mem_addr returns to 0.
//  o_mem_owner=1 in READ through WAIT_LO. It is 0 in IDLE and FIN.
//  o_mem_wea is tied 0: the block never writes memory.
//  i_tx_done during TX_HI/TX_LO (the start cycle) is ignored. Only WAIT_* consumes it.
//  i_start while o_busy=1 is ignored. The dump is never restarted or extended.
//  Address never wraps. The terminal compare uses N_WORDS-1, so N_WORDS=RAM_DEPTH ends at 1023.
//  Stalls are unbounded: WAIT_* waits indefinitely for i_tx_done (no timeout).
//  Per word: 4 cycles plus 2 UART byte times.
// TESTING
//  1. Reset held low 3 cycles, with i_start=1 and i_tx_done=1 asserted
//     -> all outputs 0, state stays IDLE after release.
//  2. Memory preloaded 0:0xA55A, 1:0x1234. N_WORDS=2. Start pulse; TX model answers done 5 cycles after each start
//     -> bytes A5,5A,12,34 in order, then one o_done pulse, o_busy=0.
//  3. i_tx_done asserted in the same cycle as o_tx_start
//     -> ignored; FSM stays in WAIT_HI until a later done tick, and no byte is skipped.
//  4. N_WORDS=1024, memory=address value
//     -> 2048 bytes; last pair 0x03,0xFF; o_mem_addr never exceeds 1023.
//  5. i_reset=0 while in WAIT_LO of word 5
//     -> IDLE next cycle, o_mem_owner=0, no o_done.
//     A new i_start then restarts the dump from address 0.
//  6. i_start pulsed again mid-dump -> byte stream is unchanged, and exactly one o_done is issued.

Source files
------------

// File: rtl/volcado_memoria_datos.sv
// rtl/volcado_memoria_datos.sv - data memory dump engine: reads N_WORDS words and ships each as two UART bytes, high first
module volcado_memoria_datos #(
  parameter int unsigned RAM_WIDTH  = 16,
  parameter int unsigned RAM_DEPTH  = 1024,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned NB_UART    = 8,
  parameter int unsigned N_WORDS    = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [RAM_WIDTH-1:0]  i_mem_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_wea,
  output logic                  o_mem_owner,
  input  logic                  i_tx_done,
  output logic                  o_tx_start,
  output logic [NB_UART-1:0]    o_tx_data,
  output logic                  o_busy,
  output logic                  o_done
);

  // Out-of-range word counts are clamped so the address can never run past the memory.
  localparam int unsigned N_EFF = (N_WORDS > RAM_DEPTH) ? RAM_DEPTH : N_WORDS;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_EFF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_TX_HI, S_WAIT_HI, S_TX_LO, S_WAIT_LO, S_FIN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RAM_WIDTH-1:0]  word_q, word_d;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    word_d      = word_q;
    o_tx_start  = 1'b0;
    o_done      = 1'b0;
    o_mem_owner = 1'b0;
    o_busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        o_mem_owner = 1'b1;
        state_d     = S_LATCH;
      end
      S_LATCH: begin
        o_mem_owner = 1'b1;
        word_d      = i_mem_data;
        state_d     = S_TX_HI;
      end
      S_TX_HI: begin
        o_mem_owner = 1'b1;
        o_tx_start  = 1'b1;
        state_d     = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        o_mem_owner = 1'b1;
        if (i_tx_done) state_d = S_TX_LO;
      end
      S_TX_LO: begin
        o_mem_owner = 1'b1;
        o_tx_start  = 1'b1;
        state_d     = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        o_mem_owner = 1'b1;
        if (i_tx_done) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_FIN;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = S_READ;
          end
        end
      end
      S_FIN: begin
        o_done  = 1'b1;
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The low byte stays on the bus until the next word is latched, so the data is held through every wait.
  assign o_tx_data  = (state_q == S_TX_HI || state_q == S_WAIT_HI) ?
                      word_q[RAM_WIDTH-1 -: NB_UART] : word_q[NB_UART-1:0];
  assign o_mem_addr = addr_q;
  assign o_mem_wea  = 1'b0;

endmodule

// File: tb/tb_volcado_memoria_datos.sv
// tb/tb_volcado_memoria_datos.sv - bench: two dump engines (2 words and 1024 words) against a byte-stream model
module tb_volcado_memoria_datos;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start;
  logic             force_done;
  logic [1:0]       resp_done;
  logic [1:0]       tx_done_w;
  logic [1:0][9:0]  mem_addr;
  logic [1:0]       wea, owner, tx_start, busy, done;
  logic [1:0][7:0]  tx_data;
  logic [1:0][15:0] rd_data;

  logic [15:0] mem_a [1024];
  logic [15:0] mem_b [1024];

  assign tx_done_w = resp_done | {2{force_done}};

  volcado_memoria_datos #(.N_WORDS(2)) dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_mem_data(rd_data[0]),
    .o_mem_addr(mem_addr[0]), .o_mem_wea(wea[0]), .o_mem_owner(owner[0]),
    .i_tx_done(tx_done_w[0]), .o_tx_start(tx_start[0]), .o_tx_data(tx_data[0]),
    .o_busy(busy[0]), .o_done(done[0])
  );

  volcado_memoria_datos #(.N_WORDS(1024)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_mem_data(rd_data[1]),
    .o_mem_addr(mem_addr[1]), .o_mem_wea(wea[1]), .o_mem_owner(owner[1]),
    .i_tx_done(tx_done_w[1]), .o_tx_start(tx_start[1]), .o_tx_data(tx_data[1]),
    .o_busy(busy[1]), .o_done(done[1])
  );

  // Data memory: address sampled on the falling edge.
  always @(negedge clk) begin
    rd_data[0] <= mem_a[mem_addr[0]];
    rd_data[1] <= mem_b[mem_addr[1]];
  end

  // UART TX stand-in: done tick dly cycles after each start; glitch also ticks in the start cycle.
  int cnt [2];
  int dly [2];
  bit glitch [2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      resp_done[d] = 1'b0;
      if (!rst_n) begin
        cnt[d] = 0;
      end else begin
        if (cnt[d] > 0) begin
          cnt[d] = cnt[d] - 1;
          if (cnt[d] == 0) resp_done[d] = 1'b1;
        end
        if (tx_start[d]) begin
          cnt[d] = dly[d];
          if (glitch[d]) resp_done[d] = 1'b1;
        end
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the dump is the byte sequence hi(mem[0]), lo(mem[0]), hi(mem[1]), ... of 2*N_WORDS bytes.
  int         nw [2] = '{2, 1024};
  int         seen [2];
  int         done_cnt [2];
  int         runs [2];
  int         max_addr [2];
  int         first_addr [2];
  bit         active [2];
  logic [7:0] last_b [2];
  logic [7:0] prev_b [2];
  logic [7:0] first_b [2];
  logic [7:0] cap_a [4];

  function automatic logic [7:0] exp_byte(input int d, input int n);
    logic [9:0]  idx;
    logic [15:0] w;
    idx = 10'(n / 2);
    w   = (d == 0) ? mem_a[idx] : mem_b[idx];
    return (n % 2 == 1) ? w[7:0] : w[15:8];
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("wea_zero", 32'(wea[d]), 32'd0);
      chk("owner", 32'(owner[d]), 32'(busy[d] & ~done[d]));
      if (busy[d]) begin
        chk("addr_range", 32'(int'(mem_addr[d]) <= nw[d] - 1), 32'd1);
        if (int'(mem_addr[d]) > max_addr[d]) max_addr[d] = int'(mem_addr[d]);
      end else begin
        chk("idle_quiet", 32'({tx_start[d], done[d]}), 32'd0);
      end
      if (tx_start[d]) begin
        chk("start_expected", 32'(active[d] && seen[d] < 2 * nw[d]), 32'd1);
        chk("tx_byte", 32'(tx_data[d]), 32'(exp_byte(d, seen[d])));
        chk("tx_addr", 32'(mem_addr[d]), 32'(seen[d] / 2));
        if (seen[d] == 0) begin
          first_b[d]    = tx_data[d];
          first_addr[d] = int'(mem_addr[d]);
        end
        if (d == 0 && seen[d] < 4) cap_a[seen[d]] = tx_data[d];
        prev_b[d] = last_b[d];
        last_b[d] = tx_data[d];
        seen[d]++;
      end else if (busy[d] && seen[d] > 0) begin
        chk("tx_hold", 32'(tx_data[d]), 32'(last_b[d]));
      end
      if (done[d]) begin
        chk("done_complete", 32'(active[d] && seen[d] == 2 * nw[d]), 32'd1);
        done_cnt[d]++;
        runs[d]++;
        active[d] = 1'b0;
      end
      if (!rst_n) begin
        active[d] = 1'b0;
        seen[d]   = 0;
      end else if (start && !busy[d]) begin
        active[d]   = 1'b1;
        seen[d]     = 0;
        done_cnt[d] = 0;
        max_addr[d] = 0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_run(input int d, input int prev, input int budget, input string name);
    int n = 0;
    while (runs[d] <= prev && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(runs[d] > prev), 32'd1);
  endtask

  task automatic wait_seen(input int d, input int target, input int budget, input string name);
    int n = 0;
    while (seen[d] < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(seen[d] >= target), 32'd1);
  endtask

  int prev;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'(i);
    end
    mem_a[0] = 16'hA55A;
    mem_a[1] = 16'h1234;
    dly[0] = 5; dly[1] = 2;
    glitch[0] = 1'b0; glitch[1] = 1'b0;

    // Reset held with start and done asserted.
    rst_n = 1'b0; start = 1'b1; force_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_addr", 32'(mem_addr[d]), 32'd0);
      chk("rst_data", 32'(tx_data[d]), 32'd0);
      chk("rst_owner", 32'(owner[d]), 32'd0);
      chk("rst_txstart", 32'(tx_start[d]), 32'd0);
      chk("rst_done", 32'(done[d]), 32'd0);
    end
    rst_n = 1'b1; start = 1'b0; force_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Two-word dump, done 5 cycles after each start.
    prev = runs[0];
    pulse_start();
    wait_run(0, prev, 300, "run_a1_timeout");
    chk("a1_b0", 32'(cap_a[0]), 32'hA5);
    chk("a1_b1", 32'(cap_a[1]), 32'h5A);
    chk("a1_b2", 32'(cap_a[2]), 32'h12);
    chk("a1_b3", 32'(cap_a[3]), 32'h34);
    @(posedge clk); #1;
    chk("a1_busy_after", 32'(busy[0]), 32'd0);
    chk("a1_done_count", 32'(done_cnt[0]), 32'd1);

    // Done tick coinciding with tx_start must be ignored; also a mid-dump start for the long engine.
    glitch[0] = 1'b1;
    cap_a[0] = 8'h00; cap_a[1] = 8'h00; cap_a[2] = 8'h00; cap_a[3] = 8'h00;
    prev = runs[0];
    pulse_start();
    wait_run(0, prev, 300, "run_a2_timeout");
    chk("a2_b0", 32'(cap_a[0]), 32'hA5);
    chk("a2_b1", 32'(cap_a[1]), 32'h5A);
    chk("a2_b2", 32'(cap_a[2]), 32'h12);
    chk("a2_b3", 32'(cap_a[3]), 32'h34);
    chk("a2_bytes", 32'(seen[0]), 32'd4);
    glitch[0] = 1'b0;
    repeat (40) @(posedge clk);
    pulse_start();

    // Full 1024-word dump.
    wait_run(1, 0, 12000, "run_b1_timeout");
    chk("b1_bytes", 32'(seen[1]), 32'd2048);
    chk("b1_last_hi", 32'(prev_b[1]), 32'h03);
    chk("b1_last_lo", 32'(last_b[1]), 32'hFF);
    chk("b1_max_addr", 32'(max_addr[1]), 32'd1023);
    repeat (20) @(posedge clk);
    #1;
    chk("b1_done_count", 32'(done_cnt[1]), 32'd1);
    chk("b1_idle", 32'(busy[1]), 32'd0);

    // Abort in WAIT_LO of word 5, then restart from address 0.
    prev = runs[1];
    pulse_start();
    wait_seen(1, 12, 300, "b2_word5_timeout");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy[1]), 32'd0);
    chk("abort_owner", 32'(owner[1]), 32'd0);
    chk("abort_addr", 32'(mem_addr[1]), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(runs[1]), 32'(prev));
    chk("abort_no_tx", 32'(seen[1]), 32'd0);
    pulse_start();
    wait_seen(1, 1, 50, "b3_first_timeout");
    chk("b3_first_byte", 32'(first_b[1]), 32'h00);
    chk("b3_first_addr", 32'(first_addr[1]), 32'd0);
    wait_run(1, prev, 12000, "run_b3_timeout");
    chk("b3_bytes", 32'(seen[1]), 32'd2048);
    chk("b3_done_count", 32'(done_cnt[1]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
